// File: rtl/log2_stream_approx.sv
// Streaming Mitchell-approximation log2/ln of unsigned mel energies.
// Three-stage pipeline with a single global enable driven by output backpressure.
module log2_stream_approx #(
    parameter int NUM_MELS         = 40,
    parameter int MEL_ENERGY_WIDTH = 32,
    parameter int FRAC_BITS        = 10,
    parameter int LN2_Q16          = 45426,
    localparam int LOG_WIDTH = $clog2(MEL_ENERGY_WIDTH) + FRAC_BITS,
    localparam int CH_WIDTH  = $clog2(NUM_MELS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MEL_ENERGY_WIDTH-1:0] in_data,
    input  logic                        in_last,
    input  logic                        in_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LOG_WIDTH-1:0]        out_data,
    output logic [CH_WIDTH-1:0]         out_ch,
    output logic                        out_last,
    output logic                        out_zero,
    output logic                        frame_err
);

    localparam int W     = MEL_ENERGY_WIDTH;
    localparam int F     = FRAC_BITS;
    localparam int PW    = $clog2(W);
    localparam int PRODW = LOG_WIDTH + 17;
    localparam logic [16:0]         LN2     = 17'(LN2_Q16);
    localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(NUM_MELS - 1);

    logic en;
    logic accept;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign accept   = in_valid && en;

    logic [CH_WIDTH-1:0] ch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt    <= '0;
            frame_err <= 1'b0;
        end else if (accept) begin
            ch_cnt <= (in_last || ch_cnt == LAST_CH) ? '0 : ch_cnt + 1'b1;
            if (in_last != (ch_cnt == LAST_CH))
                frame_err <= 1'b1;
        end
    end

    // Stage 1: leading-one position and left-normalised mantissa
    logic [PW-1:0] lead;
    logic [W-1:0]  norm;

    always_comb begin
        lead = '0;
        for (int unsigned i = 0; i < W; i++)
            if (in_data[i])
                lead = PW'(i);
        norm = in_data << (PW'(W - 1) - lead);
    end

    logic                s1_valid, s1_zero, s1_mode, s1_last;
    logic [PW-1:0]       s1_p;
    logic [W-1:0]        s1_mant;
    logic [CH_WIDTH-1:0] s1_ch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_mode  <= 1'b0;
            s1_last  <= 1'b0;
            s1_p     <= '0;
            s1_mant  <= '0;
            s1_ch    <= '0;
        end else if (en) begin
            s1_valid <= accept;
            s1_zero  <= (in_data == '0);
            s1_mode  <= in_mode;
            s1_last  <= in_last;
            s1_p     <= lead;
            s1_mant  <= norm;
            s1_ch    <= ch_cnt;
        end
    end

    // Stage 2: drop the implicit leading one; the F bits below it become the
    // fraction, zero-padded on the right when the input is narrower than F.
    logic [W+F-1:0]       ext;
    logic [F-1:0]         frac;
    logic [LOG_WIDTH-1:0] s1_log;

    always_comb begin
        ext    = {s1_mant, {F{1'b0}}};
        frac   = F'(ext >> (W - 1));
        s1_log = {s1_p, frac};
    end

    logic                 s2_valid, s2_zero, s2_mode, s2_last;
    logic [LOG_WIDTH-1:0] s2_log;
    logic [CH_WIDTH-1:0]  s2_ch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_zero  <= 1'b0;
            s2_mode  <= 1'b0;
            s2_last  <= 1'b0;
            s2_log   <= '0;
            s2_ch    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_zero  <= s1_zero;
            s2_mode  <= s1_mode;
            s2_last  <= s1_last;
            s2_log   <= s1_log;
            s2_ch    <= s1_ch;
        end
    end

    // Stage 3: optional ln scaling, floor of log2 * ln(2)
    logic [PRODW-1:0]     prod;
    logic [LOG_WIDTH-1:0] result;

    always_comb begin
        prod = PRODW'(s2_log) * PRODW'(LN2);
        if (s2_zero)
            result = '0;
        else if (s2_mode)
            result = LOG_WIDTH'(prod >> 16);
        else
            result = s2_log;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_data  <= result;
            out_ch    <= s2_ch;
            out_last  <= s2_last;
            out_zero  <= s2_zero;
        end
    end

endmodule
